// File: rtl/neighbor_link_pkg.sv
// neighbor_link_pkg: shared width derivations and payload flag positions for the neighbor link channel
package neighbor_link_pkg;
  function automatic int link_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int address_width(input int per_dim);
    return 3 * per_dim;
  endfunction
  function automatic int payload_width(input int per_dim);
    return address_width(per_dim) + 2;
  endfunction
  function automatic int increase_bit(input int per_dim);
    return address_width(per_dim);
  endfunction
  function automatic int odd_cluster_bit(input int per_dim);
    return address_width(per_dim) + 1;
  endfunction
endpackage

// File: rtl/neighbor_link_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant starting after the last popped index, pointer moves only on advance
module rr_arbiter
  import neighbor_link_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int LW = link_id_width(N);
  logic [LW-1:0] last, idx;
  always_comb begin
    grant = '0;
    idx = last;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        grant = '0;
        grant[(int'(last) + k) % N] = 1'b1;
        idx = LW'((int'(last) + k) % N);
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) last <= LW'(N - 1);
    else if (advance) last <= idx;
endmodule

// File: rtl/neighbor_link_arbiter.sv
// neighbor_link_arbiter: shares one channel among boundary links (tx round-robin, rx steering, idle detect); NEIGHBOR_ARB_OUT_REG_EN adds a registered tx stage
module neighbor_link_arbiter
  import neighbor_link_pkg::*;
#(
  parameter int PER_DIMENSION_WIDTH = 4,
  parameter int NUM_LINKS = 4,
  parameter int IDLE_CYCLES = 8,
  localparam int ADDRESS_WIDTH = address_width(PER_DIMENSION_WIDTH),
  localparam int PAYLOAD_WIDTH = ADDRESS_WIDTH + 2,
  localparam int LINK_ID_WIDTH = link_id_width(NUM_LINKS),
  localparam int CH_WIDTH = LINK_ID_WIDTH + PAYLOAD_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               initialize,
  input  logic [NUM_LINKS*PAYLOAD_WIDTH-1:0] link_out_data,
  input  logic [NUM_LINKS-1:0]               link_out_valid,
  output logic [NUM_LINKS-1:0]               link_out_ready,
  output logic [CH_WIDTH-1:0]                ch_tx_data,
  output logic                               ch_tx_valid,
  input  logic                               ch_tx_ready,
  input  logic [CH_WIDTH-1:0]                ch_rx_data,
  input  logic                               ch_rx_valid,
  output logic                               ch_rx_ready,
  output logic [PAYLOAD_WIDTH-1:0]           link_in_data,
  output logic [NUM_LINKS-1:0]               link_in_valid,
  output logic                               bad_link_id,
  output logic                               idle
);
  localparam int CW = $clog2(IDLE_CYCLES + 1);
  logic clr, pop, quiet, rx_ok;
  logic [NUM_LINKS-1:0] grant;
  logic [LINK_ID_WIDTH-1:0] gidx, rx_id;
  logic [CH_WIDTH-1:0] head;
  logic [CW-1:0] cnt;
  assign clr = reset | initialize;
  rr_arbiter #(.N(NUM_LINKS)) u_rr (
    .clk(clk),
    .reset(clr),
    .req(link_out_valid),
    .advance(pop),
    .grant(grant)
  );
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_LINKS; i++) gidx = grant[i] ? LINK_ID_WIDTH'(i) : gidx;
  end
  assign head = {gidx, link_out_data[int'(gidx)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]};
  assign link_out_ready = pop ? grant : '0;
`ifdef NEIGHBOR_ARB_OUT_REG_EN
  logic reg_v;
  logic [CH_WIDTH-1:0] reg_d;
  assign pop = !clr && (|link_out_valid) && (!reg_v || ch_tx_ready);
  always_ff @(posedge clk)
    if (clr) begin
      reg_v <= 1'b0;
      reg_d <= '0;
    end else if (pop) begin
      reg_v <= 1'b1;
      reg_d <= head;
    end else if (ch_tx_ready) reg_v <= 1'b0;
  assign ch_tx_valid = reg_v && !clr;
  assign ch_tx_data = clr ? '0 : reg_d;
`else
  assign ch_tx_valid = !clr && (|link_out_valid);
  assign ch_tx_data = ch_tx_valid ? head : '0;
  assign pop = ch_tx_valid && ch_tx_ready;
`endif
  assign rx_id = ch_rx_data[CH_WIDTH-1 -: LINK_ID_WIDTH];
  assign rx_ok = int'(rx_id) < NUM_LINKS;
  assign link_in_data = ch_rx_data[PAYLOAD_WIDTH-1:0];
  assign link_in_valid = (!clr && ch_rx_valid && rx_ok) ? ({{(NUM_LINKS-1){1'b0}}, 1'b1} << rx_id) : '0;
  assign ch_rx_ready = 1'b1;
  assign quiet = !(|link_out_valid) && !ch_tx_valid && !ch_rx_valid;
  assign idle = cnt == CW'(IDLE_CYCLES);
  always_ff @(posedge clk)
    if (clr) begin
      cnt <= '0;
      bad_link_id <= 1'b0;
    end else begin
      cnt <= !quiet ? '0 : idle ? cnt : cnt + 1'b1;
      if (ch_rx_valid && !rx_ok) bad_link_id <= 1'b1;
    end
endmodule

// File: tb/tb_neighbor_link_arbiter.sv
// tb_neighbor_link_arbiter: randomized traffic against a queue-based reference model, plus a 3-link instance for bad ids
module tb_neighbor_link_arbiter;
  localparam int NL = 4, PW = 14, CW = 16, IC = 8;
  logic clk = 1'b0;
  logic reset, initialize, ch_tx_ready, ch_rx_valid;
  logic [NL*PW-1:0] link_out_data;
  logic [NL-1:0] link_out_valid, link_out_ready, link_in_valid;
  logic [CW-1:0] ch_tx_data, ch_rx_data;
  logic ch_tx_valid, ch_rx_ready, bad_link_id, idle;
  logic [PW-1:0] link_in_data;
  logic [2:0] link_out_ready3, link_in_valid3;
  logic [CW-1:0] ch_tx_data3;
  logic ch_tx_valid3, ch_rx_ready3, bad3_o, idle3;
  logic [PW-1:0] link_in_data3;
  logic [PW-1:0] q [NL][$];
  int last, run, run3, n_checks, n_errors;
  bit bad, bad3, started;
  always #5 clk = ~clk;
  neighbor_link_arbiter dut (
    .clk(clk), .reset(reset), .initialize(initialize),
    .link_out_data(link_out_data), .link_out_valid(link_out_valid), .link_out_ready(link_out_ready),
    .ch_tx_data(ch_tx_data), .ch_tx_valid(ch_tx_valid), .ch_tx_ready(ch_tx_ready),
    .ch_rx_data(ch_rx_data), .ch_rx_valid(ch_rx_valid), .ch_rx_ready(ch_rx_ready),
    .link_in_data(link_in_data), .link_in_valid(link_in_valid),
    .bad_link_id(bad_link_id), .idle(idle)
  );
  neighbor_link_arbiter #(.NUM_LINKS(3)) dut3 (
    .clk(clk), .reset(reset), .initialize(initialize),
    .link_out_data('0), .link_out_valid(3'b000), .link_out_ready(link_out_ready3),
    .ch_tx_data(ch_tx_data3), .ch_tx_valid(ch_tx_valid3), .ch_tx_ready(ch_tx_ready),
    .ch_rx_data(ch_rx_data), .ch_rx_valid(ch_rx_valid), .ch_rx_ready(ch_rx_ready3),
    .link_in_data(link_in_data3), .link_in_valid(link_in_valid3),
    .bad_link_id(bad3_o), .idle(idle3)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input bit r, input bit in, input bit rdy, input bit rxv, input logic [CW-1:0] rxd);
    int g, id;
    bit clr, anyv;
    logic [NL-1:0] e4;
    logic [2:0] e3;
    @(negedge clk);
    reset = r;
    initialize = in;
    ch_tx_ready = rdy;
    ch_rx_valid = rxv;
    ch_rx_data = rxd;
    for (int i = 0; i < NL; i++) begin
      link_out_valid[i] = q[i].size() > 0;
      link_out_data[i*PW +: PW] = (q[i].size() > 0) ? q[i][0] : PW'($urandom);
    end
    #1;
    if (started) begin
      check("idle", idle, run >= IC);
      check("bad_link_id", bad_link_id, bad);
      check("idle3", idle3, run3 >= IC);
      check("bad_link_id3", bad3_o, bad3);
    end
    clr = r || in;
    anyv = |link_out_valid;
    g = -1;
    for (int k = 1; k <= NL; k++) if (g < 0 && q[(last + k) % NL].size() > 0) g = (last + k) % NL;
    check("tx_valid", ch_tx_valid, !clr && anyv);
    if (clr) check("tx_data_clr", ch_tx_data, 0);
    else if (anyv) check("tx_data", ch_tx_data, (64'(g) << PW) | 64'(q[g][0]));
    e4 = (!clr && anyv && rdy) ? NL'(1) << g : '0;
    check("link_out_ready", link_out_ready, e4);
    id = int'(rxd[CW-1 -: 2]);
    e4 = (!clr && rxv) ? NL'(1) << id : '0;
    check("link_in_valid", link_in_valid, e4);
    if (rxv) check("link_in_data", link_in_data, rxd[PW-1:0]);
    e3 = (!clr && rxv && id < 3) ? 3'(1) << id : '0;
    check("link_in_valid3", link_in_valid3, e3);
    check("tx_valid3", ch_tx_valid3, 0);
    check("rx_ready", {ch_rx_ready, ch_rx_ready3}, 2'b11);
    if (clr) begin
      last = NL - 1;
      run = 0;
      run3 = 0;
      bad = 0;
      bad3 = 0;
      started = 1;
    end else begin
      if (anyv && rdy) begin
        void'(q[g].pop_front());
        last = g;
      end
      run = (!anyv && !rxv) ? run + 1 : 0;
      run3 = !rxv ? run3 + 1 : 0;
      if (rxv && id >= 3) bad3 = 1;
    end
  endtask
  initial begin
    reset = 1'b1;
    initialize = 1'b0;
    ch_tx_ready = 1'b0;
    ch_rx_valid = 1'b0;
    ch_rx_data = '0;
    link_out_valid = '0;
    link_out_data = '0;
    last = NL - 1;
    cycle(1, 0, 0, 0, '0);
    repeat (11) cycle(0, 0, 0, 0, '0);
    for (int i = 0; i < NL; i++) q[i].push_back(PW'($urandom));
    repeat (5) cycle(0, 0, 1, 0, '0);
    q[2].push_back(14'h3ABC);
    repeat (5) cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 0, 1, {2'd1, 14'h1005});
    cycle(0, 0, 0, 1, {2'd3, 14'h0042});
    cycle(0, 0, 0, 0, '0);
    q[1].push_back(PW'($urandom));
    q[3].push_back(PW'($urandom));
    cycle(0, 1, 1, 0, '0);
    repeat (3) cycle(0, 0, 1, 0, '0);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < NL; i++) if ($urandom_range(0, 2) == 0 && q[i].size() < 4) q[i].push_back(PW'($urandom));
        cycle($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, CW'($urandom));
      end
      repeat (30) cycle(0, 0, 1, 0, '0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
